// File: rtl/scan_pkg.sv
// scan_pkg: shared scan-mode encodings and segment-length helper for the scan register bank.
package scan_pkg;

  localparam logic [1:0] SCAN_SHIFT   = 2'd0;
  localparam logic [1:0] SCAN_CAPTURE = 2'd1;
  localparam logic [1:0] SCAN_HOLD    = 2'd2;

  function automatic int seg_len(input int width, input int nchain);
    return width / nchain;
  endfunction

  function automatic logic [1:0] scan_mode(input logic se, input logic en);
    return se ? SCAN_SHIFT : en ? SCAN_CAPTURE : SCAN_HOLD;
  endfunction

endpackage

// File: rtl/scan_chain_seg.sv
// scan_chain_seg: one L-bit mux-scan segment; shifts toward bit 0, which drives SO straight from the flop.
module scan_chain_seg #(
  parameter int           L       = 8,
  parameter logic [L-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         se_i,
  input  logic         en_i,
  input  logic         si_i,
  input  logic [L-1:0] d_i,
  output logic [L-1:0] sr_o,
  output logic         so_o
);

  logic [L-1:0] sr_q, sr_d;

  // Ternary select keeps an X on se visible in sr instead of silently picking a branch.
  always_comb sr_d = se_i ? {si_i, sr_q[L-1:1]} : en_i ? d_i : sr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) sr_q <= RST_VAL;
    else       sr_q <= sr_d;
  end

  assign sr_o = sr_q;
  assign so_o = sr_q[0];

endmodule

// File: rtl/scan_reg_bank.sv
// scan_reg_bank: multi-chain mux-scan register bank with capture enable, optional shadow stage
// and a shift-length counter pulsing SHIFT_DONE after each full segment.
module scan_reg_bank
  import scan_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter int               NCHAIN  = 2,
  parameter bit               SHADOW  = 1'b1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              se_i,
  input  logic              en_i,
  input  logic              upd_i,
  input  logic [WIDTH-1:0]  d_i,
  input  logic [NCHAIN-1:0] si_i,
  output logic [WIDTH-1:0]  q_o,
  output logic [NCHAIN-1:0] so_o,
  output logic              shift_done_o
);

  localparam int L  = seg_len(WIDTH, NCHAIN);
  localparam int CW = (L < 2) ? 1 : $clog2(L);

  if ((WIDTH % NCHAIN) != 0 || L < 2) begin : g_bad_cfg
    $error("scan_reg_bank: WIDTH must be a multiple of NCHAIN with segment length >= 2");
  end

  logic [WIDTH-1:0] sr;

  for (genvar c = 0; c < NCHAIN; c++) begin : g_seg
    scan_chain_seg #(
      .L       (L),
      .RST_VAL (RST_VAL[c*L +: L])
    ) u_seg (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .se_i  (se_i),
      .en_i  (en_i),
      .si_i  (si_i[c]),
      .d_i   (d_i[c*L +: L]),
      .sr_o  (sr[c*L +: L]),
      .so_o  (so_o[c])
    );
  end

  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          last;

  assign last = cnt_q == CW'(L - 1);

  // Any cycle without SE discards a partial segment count.
  always_comb begin
    cnt_d  = se_i ? (last ? '0 : cnt_q + 1'b1) : '0;
    done_d = se_i && last;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign shift_done_o = done_q;

  if (SHADOW) begin : g_shadow
    logic [WIDTH-1:0] sh_q, sh_d;
    // Loads the pre-edge sr, so a capture in the same cycle reaches sh only on a later update.
    always_comb sh_d = (!se_i && upd_i) ? sr : sh_q;
    always_ff @(posedge clk_i) begin
      if (rst_i) sh_q <= RST_VAL;
      else       sh_q <= sh_d;
    end
    assign q_o = sh_q;
  end else begin : g_direct
    logic unused_upd;
    assign unused_upd = upd_i;
    assign q_o = sr;
  end

endmodule

// File: tb/tb_scan_reg_bank.sv
// tb_scan_reg_bank: scoreboard bench for two scan bank configurations (16/2 shadowed, 8/4 direct).
module tb_scan_reg_bank;
  import scan_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst = 1'b1, a_se = 1'b0, a_en = 1'b0, a_upd = 1'b0;
  logic [15:0] a_d = '0, a_q;
  logic [1:0]  a_si = '0, a_so;
  logic        a_done;

  logic        b_rst = 1'b1, b_se = 1'b0, b_en = 1'b0, b_upd = 1'b0;
  logic [7:0]  b_d = '0, b_q;
  logic [3:0]  b_si = '0, b_so;
  logic        b_done;

  scan_reg_bank #(.WIDTH(16), .NCHAIN(2), .SHADOW(1'b1), .RST_VAL(16'h0000)) u_a (
    .clk_i(clk), .rst_i(a_rst), .se_i(a_se), .en_i(a_en), .upd_i(a_upd),
    .d_i(a_d), .si_i(a_si), .q_o(a_q), .so_o(a_so), .shift_done_o(a_done)
  );

  scan_reg_bank #(.WIDTH(8), .NCHAIN(4), .SHADOW(1'b0), .RST_VAL(8'h00)) u_b (
    .clk_i(clk), .rst_i(b_rst), .se_i(b_se), .en_i(b_en), .upd_i(b_upd),
    .d_i(b_d), .si_i(b_si), .q_o(b_q), .so_o(b_so), .shift_done_o(b_done)
  );

  typedef struct {
    bit          dut;
    logic [15:0] q;
    logic [3:0]  so;
    logic        done;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  int m_sr[2], m_sh[2], m_run[2];
  bit m_done[2];

  function automatic int seg_l(input bit k);  return k ? 2 : 8;  endfunction
  function automatic int n_ch(input bit k);   return k ? 4 : 2;  endfunction
  function automatic int wmask(input bit k);  return k ? 32'hFF : 32'hFFFF; endfunction

  task automatic check(input string name, input bit k, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d got %h expected %h at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic model(input bit k, input bit rst, input bit se, input bit en, input bit upd,
                       input int d, input int si);
    int l, nxt, seg;
    l = seg_l(k);
    if (rst) begin
      m_sr[k] = 0; m_sh[k] = 0; m_run[k] = 0; m_done[k] = 0;
    end else begin
      if (!se && upd) m_sh[k] = m_sr[k];
      case (scan_mode(se, en))
        SCAN_SHIFT: begin
          nxt = 0;
          for (int c = 0; c < n_ch(k); c++) begin
            seg = (m_sr[k] >> (c * l)) & ((1 << l) - 1);
            seg = (seg >> 1) | (((si >> c) & 1) << (l - 1));
            nxt = nxt | (seg << (c * l));
          end
          m_sr[k] = nxt;
        end
        SCAN_CAPTURE: m_sr[k] = d & wmask(k);
        default: ;
      endcase
      if (se) begin
        m_run[k]++;
        m_done[k] = (m_run[k] % l) == 0;
      end else begin
        m_run[k] = 0;
        m_done[k] = 0;
      end
    end
  endtask

  task automatic step(input bit k, input bit rst, input bit se, input bit en, input bit upd,
                      input logic [15:0] d, input logic [3:0] si);
    exp_t e;
    int so;
    @(negedge clk);
    if (!k) begin
      a_rst = rst; a_se = se; a_en = en; a_upd = upd; a_d = d; a_si = si[1:0];
      b_rst = 0; b_se = 0; b_en = 0; b_upd = 0;
    end else begin
      b_rst = rst; b_se = se; b_en = en; b_upd = upd; b_d = d[7:0]; b_si = si;
      a_rst = 0; a_se = 0; a_en = 0; a_upd = 0;
    end
    model(k, rst, se, en, upd, int'(d), int'(si));
    model(!k, 0, 0, 0, 0, 0, 0);
    so = 0;
    for (int c = 0; c < n_ch(k); c++) so = so | (((m_sr[k] >> (c * seg_l(k))) & 1) << c);
    e.dut  = k;
    e.q    = 16'(k ? m_sr[k] : m_sh[k]);
    e.so   = 4'(so);
    e.done = m_done[k];
    sb.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (!e.dut) begin
        check("q", 0, a_q, e.q);
        check("so", 0, {14'd0, a_so}, {12'd0, e.so});
        check("done", 0, {15'd0, a_done}, {15'd0, e.done});
      end else begin
        check("q", 1, {8'd0, b_q}, e.q);
        check("so", 1, {12'd0, b_so}, {12'd0, e.so});
        check("done", 1, {15'd0, b_done}, {15'd0, e.done});
      end
    end
  end

  initial begin
    // Reset with every other control asserted
    step(0, 1, 1, 1, 1, 16'hFFFF, 4'hF);
    step(0, 1, 1, 1, 1, 16'hFFFF, 4'hF);
    step(1, 1, 1, 1, 1, 16'hFFFF, 4'hF);
    step(1, 1, 1, 1, 1, 16'hFFFF, 4'hF);
    settle();
    check("rst_q", 0, a_q, 16'h0000);
    check("rst_so", 0, {14'd0, a_so}, 16'h0000);
    check("rst_done", 0, {15'd0, a_done}, 16'h0000);

    // Capture then update
    step(0, 0, 0, 1, 0, 16'hA5C3, 4'h0);
    settle();
    check("cap_q_hidden", 0, a_q, 16'h0000);
    step(0, 0, 0, 0, 1, 16'h0000, 4'h0);
    settle();
    check("upd_q", 0, a_q, 16'hA5C3);

    // Full segment shift of 16'h00FF
    step(0, 0, 0, 1, 0, 16'h00FF, 4'h0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, 16'h0000, 4'h0);
    settle();
    check("shift_done_pulse", 0, {15'd0, a_done}, 16'h0001);
    check("shift_q_stable", 0, a_q, 16'hA5C3);
    step(0, 0, 0, 0, 0, 16'h0000, 4'h0);
    settle();
    check("shift_done_clear", 0, {15'd0, a_done}, 16'h0000);

    // Interrupted burst
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 16'h0000, 4'($urandom));
    step(0, 0, 0, 0, 0, 16'h0000, 4'h0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, 16'h0000, 4'($urandom));

    // Update coinciding with capture
    step(0, 0, 0, 1, 0, 16'h1234, 4'h0);
    step(0, 0, 0, 1, 1, 16'hFFFF, 4'h0);
    settle();
    check("upd_en_old", 0, a_q, 16'h1234);
    step(0, 0, 0, 0, 1, 16'h0000, 4'h0);
    settle();
    check("upd_en_new", 0, a_q, 16'hFFFF);

    // Direct-output configuration
    step(1, 0, 0, 1, 0, 16'h005A, 4'h0);
    step(1, 0, 1, 0, 1, 16'h0000, 4'($urandom));
    step(1, 0, 1, 0, 0, 16'h0000, 4'($urandom));
    settle();
    check("b_done_2", 1, {15'd0, b_done}, 16'h0001);
    for (int i = 0; i < 6; i++) step(1, 0, 1, 0, 0, 16'h0000, 4'($urandom));
    step(1, 0, 0, 0, 1, 16'h0000, 4'h0);

    // Randomized traffic on both configurations
    for (int i = 0; i < 600; i++)
      step(1'($urandom), ($urandom_range(0, 31) == 0), 1'($urandom), 1'($urandom),
           1'($urandom), 16'($urandom), 4'($urandom));

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
